// File: rtl/lfsr_misr_checker_if.sv
// Purpose : bundles the control, pattern and result signals of the LFSR/MISR BIST checker.
// Latency : n/a (wires only).
// Backpressure: none; the checker paces the upstream LFSR through lfsr_en.
// Ports   : start/abort/num_words/expected/lfsr_data flow master->slave;
//           lfsr_en/busy/done/pass/signature/word_cnt flow slave->master.
interface lfsr_misr_checker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] num_words;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] lfsr_data;
    logic             lfsr_en;
    logic             busy;
    logic             done;
    logic             pass;
    logic [WIDTH-1:0] signature;
    logic [CNT_W-1:0] word_cnt;

    modport master (
        output start, abort, num_words, expected, lfsr_data,
        input  lfsr_en, busy, done, pass, signature, word_cnt
    );

    modport slave (
        input  start, abort, num_words, expected, lfsr_data,
        output lfsr_en, busy, done, pass, signature, word_cnt
    );
endinterface

// File: rtl/lfsr_misr_checker.sv
// Purpose : BIST consumer; enables the upstream LFSR for N cycles, folds each word into a MISR, compares to golden.
// Latency : start accepted at edge T -> lfsr_en high for cycles T+1..T+N -> done/pass in cycle T+N+1.
// Backpressure: none; start is ignored while busy, abort returns to IDLE at the next edge without a done pulse.
// Ports   : clk, rst (async active-low), bus (slave modport: start, abort, num_words, expected, lfsr_data in;
//           lfsr_en, busy, done, pass, signature, word_cnt out).
module lfsr_misr_checker #(
    parameter int               WIDTH     = 32,
    parameter int               CNT_W     = 16,
    parameter logic [WIDTH-1:0] MISR_POLY = 32'h0040_0007,
    parameter logic [WIDTH-1:0] MISR_SEED = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_misr_checker_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] num_q;
    logic [WIDTH-1:0] exp_q;
    logic [WIDTH-1:0] sig_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pass_q;

    logic             lfsr_en_c;
    logic             busy_c;
    logic             done_c;
    logic             accept;
    logic             last_word;
    logic [WIDTH-1:0] sig_step;

    // Abort wins over start in IDLE.
    assign accept    = (state_q == IDLE) && bus.start && !bus.abort;
    // Compare against the latched count so a changing num_words input cannot end a run early.
    assign last_word = (cnt_q == (num_q - CNT_W'(1)));
    // Shift-left MISR: the bit leaving the top folds back through the taps, then the new word is XORed in.
    assign sig_step  = {sig_q[WIDTH-2:0], 1'b0} ^ (sig_q[WIDTH-1] ? MISR_POLY : '0) ^ bus.lfsr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lfsr_en_c = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (bus.num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                lfsr_en_c = 1'b1;
                busy_c    = 1'b1;
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // pass is resolved on the edge that enters DONE so it is already valid while done is high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            num_q  <= '0;
            exp_q  <= '0;
            sig_q  <= MISR_SEED;
            cnt_q  <= '0;
            pass_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        num_q  <= bus.num_words;
                        exp_q  <= bus.expected;
                        sig_q  <= MISR_SEED;
                        cnt_q  <= '0;
                        // Empty run: the seed is the final signature.
                        pass_q <= (bus.num_words == '0) && (MISR_SEED == bus.expected);
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        // Partial signature and count are kept for debug.
                        pass_q <= 1'b0;
                    end else begin
                        sig_q <= sig_step;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (last_word) begin
                            pass_q <= (sig_step == exp_q);
                        end
                    end
                end
                DONE: begin
                    if (bus.abort) begin
                        pass_q <= 1'b0;
                    end
                end
                default: begin
                    pass_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.lfsr_en   = lfsr_en_c;
    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.pass      = pass_q;
    assign bus.signature = sig_q;
    assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_lfsr_misr_checker.sv
// Purpose : self-checking bench for lfsr_misr_checker with a behavioural MISR/LFSR reference.
// Latency : checks start-to-done distance of N+1 cycles.
// Backpressure: exercises start-while-busy, abort mid-run and abort-vs-start priority.
module tb_lfsr_misr_checker;

    localparam logic [31:0] POLY      = 32'h0040_0007;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lfsr_misr_checker_if #(.WIDTH(32), .CNT_W(16)) bus0 ();
    lfsr_misr_checker_if #(.WIDTH(32), .CNT_W(16)) bus1 ();

    lfsr_misr_checker #(.WIDTH(32), .CNT_W(16), .MISR_POLY(POLY), .MISR_SEED(32'h0000_0000))
        dut0 (.clk(clk), .rst(rst), .bus(bus0));
    lfsr_misr_checker #(.WIDTH(32), .CNT_W(16), .MISR_POLY(POLY), .MISR_SEED(32'hFFFF_FFFF))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int tests = 0;
    int fails = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pattern source for dut0: 0 = fixed word, 1 = random word per cycle, 2 = upstream LFSR.
    logic [1:0]  mode = 2'd0;
    logic [31:0] data_fix = 32'h0;
    logic [31:0] rnd_word = 32'h0;
    logic [31:0] up_lfsr;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    always @(posedge clk) begin
        #1;
        rnd_word = $urandom;
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) up_lfsr <= 32'hFFFF_FFFF;
        else if (bus0.lfsr_en) up_lfsr <= lfsr_next(up_lfsr);
    end

    assign bus0.lfsr_data = (mode == 2'd2) ? up_lfsr : ((mode == 2'd1) ? rnd_word : data_fix);

    // Monitor: every word presented while lfsr_en is high, and every done pulse.
    int unsigned en_cnt = 0;
    int unsigned done_cnt = 0;
    int unsigned last_done_cyc = 0;
    logic [31:0] seen [0:4095];

    always @(negedge clk) begin
        if (bus0.lfsr_en === 1'b1) begin
            seen[en_cnt[11:0]] = bus0.lfsr_data;
            en_cnt++;
        end
        if (bus0.done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
    end

    // Signature as a GF(2) polynomial: multiply by x modulo x^32+POLY, then add the word.
    function automatic logic [31:0] misr_fold(input logic [31:0] seed, input int unsigned first, input int unsigned n);
        logic [32:0] acc;
        logic [31:0] s;
        int unsigned idx;
        s = seed;
        for (int unsigned i = 0; i < n; i++) begin
            acc = {s, 1'b0};
            if (acc[32]) acc = acc ^ {1'b1, POLY};
            idx = first + i;
            s = acc[31:0] ^ seen[idx[11:0]];
        end
        return s;
    endfunction

    task automatic start_run(input logic [15:0] n, input logic [31:0] e, output int unsigned scyc);
        @(posedge clk); #1;
        bus0.start = 1'b1;
        bus0.num_words = n;
        bus0.expected = e;
        scyc = cyc;
        @(posedge clk); #1;
        bus0.start = 1'b0;
        bus0.num_words = 16'($urandom);
        bus0.expected = $urandom;
    endtask

    task automatic wait_done(input int unsigned base, input int budget, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt != base) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        int unsigned sc;
        #12;
        tests++; if (bus0.lfsr_en !== 1'b0 || bus0.busy !== 1'b0 || bus0.done !== 1'b0) begin
            fails++; $display("FAIL rst_ctl: en=%b busy=%b done=%b want 0 0 0", bus0.lfsr_en, bus0.busy, bus0.done); end
        tests++; if (bus0.pass !== 1'b0 || bus0.signature !== 32'h0 || bus0.word_cnt !== 16'h0) begin
            fails++; $display("FAIL rst_dat: pass=%b sig=%h cnt=%0d want 0 0 0", bus0.pass, bus0.signature, bus0.word_cnt); end
        tests++; if (bus1.signature !== 32'hFFFF_FFFF) begin
            fails++; $display("FAIL rst_seed: sig=%h want ffffffff", bus1.signature); end
        @(negedge clk); rst = 1'b1;
        mode = 2'd1;
        start_run(16'd20, 32'h0, sc);
        repeat (5) @(negedge clk);
        tests++; if (bus0.busy !== 1'b1 || bus0.word_cnt == 16'h0) begin
            fails++; $display("FAIL rst_midrun_pre: busy=%b cnt=%0d want 1 >0", bus0.busy, bus0.word_cnt); end
        #2 rst = 1'b0;
        #1;
        tests++; if (bus0.lfsr_en !== 1'b0 || bus0.busy !== 1'b0 || bus0.signature !== 32'h0 || bus0.word_cnt !== 16'h0) begin
            fails++; $display("FAIL rst_async: en=%b busy=%b sig=%h cnt=%0d want 0 0 0 0",
                              bus0.lfsr_en, bus0.busy, bus0.signature, bus0.word_cnt); end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_single_word();
        int unsigned sc, be, bd;
        mode = 2'd0; data_fix = 32'h1;
        be = en_cnt; bd = done_cnt;
        start_run(16'd1, 32'h1, sc);
        wait_done(bd, 20, "single");
        @(negedge clk);
        tests++; if (en_cnt - be != 1) begin fails++; $display("FAIL single_en: got %0d want 1", en_cnt - be); end
        tests++; if (bus0.signature !== 32'h1) begin fails++; $display("FAIL single_sig: got %h want 00000001", bus0.signature); end
        tests++; if (bus0.pass !== 1'b1 || bus0.word_cnt !== 16'd1) begin
            fails++; $display("FAIL single_pass: pass=%b cnt=%0d want 1 1", bus0.pass, bus0.word_cnt); end
        tests++; if (done_cnt - bd != 1 || bus0.done !== 1'b0 || bus0.busy !== 1'b0) begin
            fails++; $display("FAIL single_done: pulses=%0d done=%b busy=%b want 1 0 0", done_cnt - bd, bus0.done, bus0.busy); end
        tests++; if (last_done_cyc - sc != 2) begin fails++; $display("FAIL single_lat: got %0d want 2", last_done_cyc - sc); end
    endtask

    task automatic test_seed_ones();
        logic [31:0] exps [2];
        logic        want [2];
        bit          got;
        exps[0] = 32'hFFBF_FFF9; want[0] = 1'b1;
        exps[1] = 32'h0000_0000; want[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            bus1.start = 1'b1; bus1.num_words = 16'd1; bus1.expected = exps[k]; bus1.lfsr_data = 32'h0;
            @(posedge clk); #1;
            bus1.start = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (bus1.done === 1'b1) begin got = 1'b1; break; end
            end
            tests++; if (!got) begin fails++; $display("FAIL seed1_timeout_%0d: no done", k); end
            tests++; if (bus1.signature !== 32'hFFBF_FFF9 || bus1.pass !== want[k]) begin
                fails++; $display("FAIL seed1_run%0d: sig=%h pass=%b want ffbffff9 %b", k, bus1.signature, bus1.pass, want[k]); end
        end
    endtask

    task automatic test_real_lfsr();
        int unsigned sc, be, bd;
        logic [31:0] s, m;
        logic [32:0] acc;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        mode = 2'd2;
        s = 32'hFFFF_FFFF; m = 32'h0;
        for (int i = 0; i < 1000; i++) begin
            acc = {m, 1'b0};
            if (acc[32]) acc = acc ^ {1'b1, POLY};
            m = acc[31:0] ^ s;
            s = lfsr_next(s);
        end
        be = en_cnt; bd = done_cnt;
        start_run(16'd1000, m, sc);
        wait_done(bd, 1100, "lfsr");
        @(negedge clk);
        tests++; if (en_cnt - be != 1000) begin fails++; $display("FAIL lfsr_en: got %0d want 1000", en_cnt - be); end
        tests++; if (bus0.signature !== m) begin fails++; $display("FAIL lfsr_sig: got %h want %h", bus0.signature, m); end
        tests++; if (bus0.pass !== 1'b1 || bus0.word_cnt !== 16'd1000) begin
            fails++; $display("FAIL lfsr_pass: pass=%b cnt=%0d want 1 1000", bus0.pass, bus0.word_cnt); end
        tests++; if (last_done_cyc - sc != 1001) begin fails++; $display("FAIL lfsr_lat: got %0d want 1001", last_done_cyc - sc); end
    endtask

    task automatic test_zero_words();
        int unsigned sc, be, bd;
        mode = 2'd0; data_fix = $urandom;
        be = en_cnt; bd = done_cnt;
        start_run(16'd0, 32'h0, sc);
        wait_done(bd, 5, "zero");
        @(negedge clk);
        tests++; if (en_cnt != be) begin fails++; $display("FAIL zero_en: got %0d want 0", en_cnt - be); end
        tests++; if (last_done_cyc - sc != 1) begin fails++; $display("FAIL zero_lat: got %0d want 1", last_done_cyc - sc); end
        tests++; if (bus0.signature !== 32'h0 || bus0.pass !== 1'b1 || bus0.word_cnt !== 16'd0) begin
            fails++; $display("FAIL zero_res: sig=%h pass=%b cnt=%0d want 0 1 0", bus0.signature, bus0.pass, bus0.word_cnt); end
    endtask

    task automatic test_start_ignored();
        int unsigned sc, be, bd;
        logic [31:0] e, m;
        mode = 2'd1; e = $urandom;
        be = en_cnt; bd = done_cnt;
        start_run(16'd12, e, sc);
        repeat (3) @(posedge clk);
        #1; bus0.start = 1'b1; bus0.num_words = 16'd3; bus0.expected = ~e;
        @(posedge clk); #1; bus0.start = 1'b0;
        wait_done(bd, 40, "busy_start");
        @(negedge clk);
        m = misr_fold(32'h0, be, 12);
        tests++; if (en_cnt - be != 12 || bus0.word_cnt !== 16'd12) begin
            fails++; $display("FAIL busy_start_cnt: en=%0d cnt=%0d want 12 12", en_cnt - be, bus0.word_cnt); end
        tests++; if (bus0.signature !== m || bus0.pass !== (m == e)) begin
            fails++; $display("FAIL busy_start_sig: sig=%h pass=%b want %h %b", bus0.signature, bus0.pass, m, (m == e)); end
        tests++; if (last_done_cyc - sc != 13) begin fails++; $display("FAIL busy_start_lat: got %0d want 13", last_done_cyc - sc); end
    endtask

    task automatic test_abort();
        int unsigned sc, be, bd;
        logic [31:0] e, m;
        bit got;
        mode = 2'd1;
        be = en_cnt; bd = done_cnt;
        start_run(16'd10, $urandom, sc);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus0.word_cnt === 16'd5) begin got = 1'b1; break; end
        end
        tests++; if (!got) begin fails++; $display("FAIL abort_reach5: cnt=%0d want 5", bus0.word_cnt); end
        bus0.abort = 1'b1;
        @(posedge clk); #1; bus0.abort = 1'b0;
        @(negedge clk);
        m = misr_fold(32'h0, be, 5);
        tests++; if (bus0.busy !== 1'b0 || bus0.lfsr_en !== 1'b0 || bus0.word_cnt !== 16'd5 || bus0.pass !== 1'b0) begin
            fails++; $display("FAIL abort_state: busy=%b en=%b cnt=%0d pass=%b want 0 0 5 0",
                              bus0.busy, bus0.lfsr_en, bus0.word_cnt, bus0.pass); end
        tests++; if (bus0.signature !== m) begin fails++; $display("FAIL abort_sig: got %h want %h", bus0.signature, m); end
        repeat (3) @(negedge clk);
        tests++; if (done_cnt != bd) begin fails++; $display("FAIL abort_nodone: pulses=%0d want 0", done_cnt - bd); end
        // Simultaneous start and abort in IDLE must not start a run.
        @(posedge clk); #1; bus0.start = 1'b1; bus0.abort = 1'b1; bus0.num_words = 16'd4;
        @(posedge clk); #1; bus0.start = 1'b0; bus0.abort = 1'b0;
        @(negedge clk);
        tests++; if (bus0.busy !== 1'b0 || bus0.lfsr_en !== 1'b0) begin
            fails++; $display("FAIL abort_prio: busy=%b en=%b want 0 0", bus0.busy, bus0.lfsr_en); end
        e = $urandom;
        be = en_cnt; bd = done_cnt;
        start_run(16'd10, e, sc);
        wait_done(bd, 30, "rerun");
        @(negedge clk);
        m = misr_fold(32'h0, be, 10);
        tests++; if (en_cnt - be != 10 || bus0.word_cnt !== 16'd10) begin
            fails++; $display("FAIL rerun_cnt: en=%0d cnt=%0d want 10 10", en_cnt - be, bus0.word_cnt); end
        tests++; if (bus0.signature !== m || bus0.pass !== (m == e)) begin
            fails++; $display("FAIL rerun_sig: sig=%h pass=%b want %h %b", bus0.signature, bus0.pass, m, (m == e)); end
    endtask

    initial begin
        bus0.start = 1'b0; bus0.abort = 1'b0; bus0.num_words = 16'h0; bus0.expected = 32'h0;
        bus1.start = 1'b0; bus1.abort = 1'b0; bus1.num_words = 16'h0; bus1.expected = 32'h0;
        bus1.lfsr_data = 32'h0;
        test_reset();
        test_single_word();
        test_seed_ones();
        test_real_lfsr();
        test_zero_words();
        test_start_ignored();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

endmodule
